fan_temp_ctrl: RTL and testbench

FAN_TEMP_CTRL -- requirements
Module: fan_temp_ctrl

---
 rtl/fan_pkg.sv | 44 ++++
 rtl/fan_pwm.sv | 28 ++
 rtl/fan_temp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fan_temp_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared types and default constants for the fan temperature controller:
// FSM state encoding, parameter defaults, PWM width and the target-duty curve.
package fan_pkg;

    localparam int PWM_W = 8;

    localparam logic [23:0]        POLL_DIV_DEF    = 24'd500000;
    localparam logic [23:0]        TIMEOUT_DEF     = 24'd100000;
    localparam logic signed [7:0]  T_LOW_DEF       = 8'sd30;
    localparam logic [7:0]         SLOPE_DEF       = 8'd8;
    localparam logic [7:0]         DUTY_MIN_DEF    = 8'd64;
    localparam logic [7:0]         HYST_DEF        = 8'd2;
    localparam logic [7:0]         SENSOR_ADDR_DEF = 8'h90;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GO_HI      = 3'd1,
        ST_GO_LO      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_CAPTURE    = 3'd5,
        ST_ERROR      = 3'd6
    } fan_state_t;

    // Linear curve above t_low; computed in 16-bit signed and clamped to full scale.
    function automatic logic [PWM_W-1:0] target_duty(
        input logic signed [7:0] temp,
        input logic signed [7:0] t_low,
        input logic [7:0]        slope,
        input logic [7:0]        duty_min
    );
        logic signed [15:0] diff;
        logic signed [15:0] acc;
        diff = $signed({{8{temp[7]}}, temp}) - $signed({{8{t_low[7]}}, t_low});
        acc  = diff * $signed({8'd0, slope}) + $signed({8'd0, duty_min});
        if (temp <= t_low)
            return duty_min;
        else if (acc > 16'sd255 || acc < 16'sd0)
            return 8'hFF;
        else
            return acc[7:0];
    endfunction

endpackage

// File: rtl/fan_pwm.sv
// Free-running 8-bit PWM; the duty register reloads only at the counter wrap
// so a period is never cut short, and full scale holds the output high.
import fan_pkg::*;

module fan_pwm (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] pending,
    output logic [PWM_W-1:0] duty,
    output logic             pwm_out
);

    logic [PWM_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            duty    <= '1;
            pwm_out <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1)
                duty <= pending;
            pwm_out <= (duty == '1) || (cnt < duty);
        end
    end

endmodule

// File: rtl/fan_temp_ctrl.sv
// Polls an I2C temperature sensor through an external read engine and drives the fan PWM.
// Define FAN_TEMP_CTRL_FAILSAFE_EN to force full duty after a failed poll.
import fan_pkg::*;

module fan_temp_ctrl #(
    parameter logic [23:0]       POLL_DIV    = POLL_DIV_DEF,
    parameter logic [23:0]       TIMEOUT     = TIMEOUT_DEF,
    parameter logic signed [7:0] T_LOW       = T_LOW_DEF,
    parameter logic [7:0]        SLOPE       = SLOPE_DEF,
    parameter logic [7:0]        DUTY_MIN    = DUTY_MIN_DEF,
    parameter logic [7:0]        HYST        = HYST_DEF,
    parameter logic [7:0]        SENSOR_ADDR = SENSOR_ADDR_DEF
) (
    input  logic        RESET_N,
    input  logic        PT_CK,
    output logic        GO,
    output logic [7:0]  SLAVE_ADDRESS,
    output logic [7:0]  BYTE_NUM,
    input  logic        END_OK,
    input  logic        ACK_OK,
    input  logic [15:0] DATA,
    output logic [7:0]  TEMP,
    output logic        TEMP_VALID,
    output logic [7:0]  DUTY,
    output logic        PWM_OUT,
    output logic        FAULT,
    output logic [7:0]  ERR_CNT,
    output logic [2:0]  fsm_state
);

    // Engine handshake: GO high for two cycles requests a read; the engine
    // drops END_OK while busy and raises it when done. ACK_OK is only
    // meaningful while END_OK is low, DATA only once END_OK has returned high.

    fan_state_t        state;
    logic [23:0]       poll_cnt;
    logic [23:0]       phase_cnt;
    logic              go_cnt;
    logic              ack_seen;
    logic              first_sample;
    logic              recover;
    logic signed [7:0] last_temp;
    logic [7:0]        pending;

    logic              poll_tick;
    logic              timeout_hit;
    logic signed [7:0] sample;
    logic signed [8:0] delta;
    logic [8:0]        delta_mag;
    logic              hyst_ok;
    logic [7:0]        target;
    logic              unused_data_lo;

    assign SLAVE_ADDRESS  = SENSOR_ADDR;
    assign BYTE_NUM       = 8'd1;
    assign GO             = (state == ST_GO_HI);
    assign fsm_state      = state;
    assign unused_data_lo = ^DATA[7:0];

    assign poll_tick   = (poll_cnt == POLL_DIV - 24'd1);
    assign timeout_hit = (phase_cnt == TIMEOUT - 24'd1);
    assign sample      = $signed(DATA[15:8]);
    assign delta       = $signed({sample[7], sample}) - $signed({last_temp[7], last_temp});
    assign delta_mag   = delta[8] ? 9'(-delta) : 9'(delta);
    assign hyst_ok     = (delta_mag >= {1'b0, HYST});
    assign target      = target_duty(sample, T_LOW, SLOPE, DUTY_MIN);

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            poll_cnt     <= '0;
            phase_cnt    <= '0;
            go_cnt       <= 1'b0;
            ack_seen     <= 1'b0;
            first_sample <= 1'b1;
            recover      <= 1'b0;
            last_temp    <= '0;
            pending      <= 8'hFF;
            TEMP         <= '0;
            TEMP_VALID   <= 1'b0;
            FAULT        <= 1'b0;
            ERR_CNT      <= '0;
        end else begin
            TEMP_VALID <= 1'b0;
            // The poll timer free-runs; ticks outside IDLE are simply lost.
            poll_cnt   <= poll_tick ? '0 : poll_cnt + 24'd1;
            case (state)
                ST_IDLE: begin
                    if (poll_tick) begin
                        state    <= ST_GO_HI;
                        go_cnt   <= 1'b0;
                        ack_seen <= 1'b0;
                    end
                end
                ST_GO_HI: begin
                    go_cnt <= 1'b1;
                    if (go_cnt)
                        state <= ST_GO_LO;
                end
                ST_GO_LO: begin
                    state     <= ST_WAIT_START;
                    phase_cnt <= '0;
                end
                ST_WAIT_START: begin
                    if (!END_OK) begin
                        state     <= ST_WAIT_DONE;
                        phase_cnt <= '0;
                    end else if (timeout_hit) begin
                        state <= ST_ERROR;
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!END_OK && ACK_OK)
                        ack_seen <= 1'b1;
                    if (END_OK)
                        state <= ST_CAPTURE;
                    else if (timeout_hit)
                        state <= ST_ERROR;
                    else
                        phase_cnt <= phase_cnt + 24'd1;
                end
                ST_CAPTURE: begin
                    if (ack_seen) begin
                        TEMP       <= sample;
                        TEMP_VALID <= 1'b1;
                        FAULT      <= 1'b0;
                        if (first_sample || recover || hyst_ok) begin
                            pending      <= target;
                            last_temp    <= sample;
                            first_sample <= 1'b0;
                        end
                        recover <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    FAULT    <= 1'b1;
                    ack_seen <= 1'b0;
                    if (ERR_CNT != 8'hFF)
                        ERR_CNT <= ERR_CNT + 8'd1;
`ifdef FAN_TEMP_CTRL_FAILSAFE_EN
                    // Fan to full until a good sample; that sample bypasses hysteresis.
                    pending <= 8'hFF;
                    recover <= 1'b1;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fan_pwm u_pwm (
        .clk     (PT_CK),
        .rst_n   (RESET_N),
        .pending (pending),
        .duty    (DUTY),
        .pwm_out (PWM_OUT)
    );

endmodule

// File: tb/tb_fan_temp_ctrl.sv
// Directed bench for fan_temp_ctrl with a behavioural I2C read-engine model.
import fan_pkg::*;

module tb_fan_temp_ctrl;

    localparam logic [23:0] POLL = 24'd600;
    localparam logic [23:0] TOUT = 24'd20;
    localparam int M_GOOD  = 0;
    localparam int M_NOACK = 1;
    localparam int M_HANG  = 2;

    logic        RESET_N;
    logic        PT_CK;
    logic        GO;
    logic [7:0]  SLAVE_ADDRESS;
    logic [7:0]  BYTE_NUM;
    logic        END_OK;
    logic        ACK_OK;
    logic [15:0] DATA;
    logic [7:0]  TEMP;
    logic        TEMP_VALID;
    logic [7:0]  DUTY;
    logic        PWM_OUT;
    logic        FAULT;
    logic [7:0]  ERR_CNT;
    logic [2:0]  fsm_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          eng_mode = M_GOOD;
    logic [15:0] eng_data = 16'h0000;

    fan_temp_ctrl #(
        .POLL_DIV (POLL),
        .TIMEOUT  (TOUT)
    ) dut (
        .RESET_N       (RESET_N),
        .PT_CK         (PT_CK),
        .GO            (GO),
        .SLAVE_ADDRESS (SLAVE_ADDRESS),
        .BYTE_NUM      (BYTE_NUM),
        .END_OK        (END_OK),
        .ACK_OK        (ACK_OK),
        .DATA          (DATA),
        .TEMP          (TEMP),
        .TEMP_VALID    (TEMP_VALID),
        .DUTY          (DUTY),
        .PWM_OUT       (PWM_OUT),
        .FAULT         (FAULT),
        .ERR_CNT       (ERR_CNT),
        .fsm_state     (fsm_state)
    );

    initial PT_CK = 1'b0;
    always #5 PT_CK = ~PT_CK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Engine model: answers each GO pulse according to eng_mode.
    initial begin
        END_OK = 1'b1;
        ACK_OK = 1'b0;
        DATA   = 16'h0000;
        forever begin
            @(negedge PT_CK);
            if (GO) begin
                while (GO) @(negedge PT_CK);
                repeat (2) @(negedge PT_CK);
                if (eng_mode != M_HANG) begin
                    END_OK = 1'b0;
                    ACK_OK = (eng_mode == M_GOOD);
                    DATA   = eng_data;
                    repeat (5) @(negedge PT_CK);
                    END_OK = 1'b1;
                    ACK_OK = 1'b0;
                end
            end
        end
    end

    // Waits for the next accepted sample or error, then one more cycle so
    // FAULT/ERR_CNT have settled.
    task automatic wait_evt(input string tag, output logic valid);
        logic done;
        done  = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge PT_CK);
            if (TEMP_VALID) begin
                valid = 1'b1;
                done  = 1'b1;
            end else if (fsm_state == ST_ERROR) begin
                done = 1'b1;
            end
        end
        if (!done)
            check({tag, "_timeout"}, 32'(done), 32'd1);
        @(negedge PT_CK);
    endtask

    task automatic check_duty(input string tag, input logic [7:0] exp);
        repeat (280) @(negedge PT_CK);
        check(tag, 32'(DUTY), 32'(exp));
    endtask

    task automatic check_highs(input string tag, input int exp);
        int highs;
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge PT_CK);
            if (PWM_OUT) highs++;
        end
        check(tag, 32'(highs), 32'(exp));
    endtask

    logic v;
    int   n;

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge PT_CK);
        check("rst_go",    32'(GO),         32'd0);
        check("rst_temp",  32'(TEMP),       32'd0);
        check("rst_valid", 32'(TEMP_VALID), 32'd0);
        check("rst_fault", 32'(FAULT),      32'd0);
        check("rst_err",   32'(ERR_CNT),    32'd0);
        check("rst_pwm",   32'(PWM_OUT),    32'd0);
        check("rst_duty",  32'(DUTY),       32'hFF);
        check("rst_state", 32'(fsm_state),  32'(ST_IDLE));
        check("addr",      32'(SLAVE_ADDRESS), 32'h90);
        check("byte_num",  32'(BYTE_NUM),   32'd1);
        RESET_N = 1'b1;

        eng_mode = M_GOOD;
        eng_data = 16'h2800;
        wait_evt("e1", v);
        check("e1_valid", 32'(v), 32'd1);
        check("e1_temp", 32'(TEMP), 32'd40);
        check("e1_fault", 32'(FAULT), 32'd0);
        eng_data = 16'h2900;
        check_duty("e1_duty", 8'd144);
        check_highs("e1_highs", 144);

        wait_evt("e2", v);
        check("e2_temp", 32'(TEMP), 32'd41);
        eng_data = 16'h2B00;
        check_duty("e2_duty_hyst", 8'd144);

        wait_evt("e3", v);
        check("e3_temp", 32'(TEMP), 32'd43);
        eng_data = 16'h1E00;
        check_duty("e3_duty", 8'd168);

        wait_evt("e4", v);
        check("e4_temp", 32'(TEMP), 32'd30);
        eng_data = 16'hFB00;
        check_duty("e4_duty_tlow", 8'd64);

        wait_evt("e5", v);
        check("e5_temp", 32'(TEMP), 32'hFB);
        eng_mode = M_NOACK;
        check_duty("e5_duty_neg", 8'd64);

        wait_evt("e6", v);
        check("e6_valid", 32'(v), 32'd0);
        check("e6_fault", 32'(FAULT), 32'd1);
        check("e6_err", 32'(ERR_CNT), 32'd1);
        check("e6_temp", 32'(TEMP), 32'hFB);
        eng_mode = M_GOOD;
        eng_data = 16'h1F00;
`ifdef FAN_TEMP_CTRL_FAILSAFE_EN
        check_duty("e6_duty", 8'd255);
`else
        check_duty("e6_duty", 8'd64);
`endif

        wait_evt("e7", v);
        check("e7_valid", 32'(v), 32'd1);
        check("e7_fault", 32'(FAULT), 32'd0);
        check("e7_temp", 32'(TEMP), 32'd31);
        eng_mode = M_HANG;
        check_duty("e7_duty", 8'd72);

        wait_evt("e8", v);
        check("e8_valid", 32'(v), 32'd0);
        check("e8_fault", 32'(FAULT), 32'd1);
        check("e8_err", 32'(ERR_CNT), 32'd2);
        eng_mode = M_GOOD;
        eng_data = 16'h2000;
`ifdef FAN_TEMP_CTRL_FAILSAFE_EN
        check_duty("e8_duty", 8'd255);
`else
        check_duty("e8_duty", 8'd72);
`endif

        wait_evt("e9", v);
        check("e9_temp", 32'(TEMP), 32'd32);
        check("e9_fault", 32'(FAULT), 32'd0);
        eng_data = 16'h5A00;
`ifdef FAN_TEMP_CTRL_FAILSAFE_EN
        check_duty("e9_duty", 8'd80);
`else
        check_duty("e9_duty", 8'd72);
`endif

        wait_evt("e10", v);
        check("e10_temp", 32'(TEMP), 32'h5A);
        check_duty("e10_duty_sat", 8'd255);
        check_highs("e10_highs", 256);

        // Reset in the middle of a transfer.
        v = 1'b0;
        for (int i = 0; i < 800 && !v; i++) begin
            @(negedge PT_CK);
            if (fsm_state == ST_WAIT_DONE) v = 1'b1;
        end
        check("rd_reach_wait_done", 32'(v), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("rd_go",    32'(GO),         32'd0);
        check("rd_state", 32'(fsm_state),  32'(ST_IDLE));
        check("rd_temp",  32'(TEMP),       32'd0);
        check("rd_err",   32'(ERR_CNT),    32'd0);
        check("rd_duty",  32'(DUTY),       32'hFF);
        check("rd_pwm",   32'(PWM_OUT),    32'd0);
        check("rd_valid", 32'(TEMP_VALID), 32'd0);
        repeat (3) @(negedge PT_CK);
        RESET_N = 1'b1;
        n = 0;
        v = 1'b0;
        for (int i = 0; i < 1000 && !v; i++) begin
            @(negedge PT_CK);
            n++;
            if (GO) v = 1'b1;
        end
        check("rd_go_seen", 32'(v), 32'd1);
        check("rd_poll_gap", 32'(n), 32'(POLL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
